core_msg_rx: RTL and testbench

CORE_MSG_RX -- requirements
Module: core_msg_rx

---
 rtl/core_msg_rx_pkg.sv | 19 +
 rtl/core_msg_rx_ibuf.sv | 26 ++
 rtl/core_msg_rx.sv | 173 +++++++++++++++++
 tb/tb_core_msg_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_msg_rx_pkg.sv
// Shared message-receiver definitions: parser state encodings, header word offsets
// and the default number of r0 data words per task header.
package core_msg_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MASK   = 3'd1,
        ST_R0MASK = 3'd2,
        ST_R0DATA = 3'd3,
        ST_ICNT   = 3'd4,
        ST_INSTR  = 3'd5
    } rx_state_t;

    localparam int HDR_MASK_OFS   = 0;
    localparam int HDR_R0MASK_OFS = 1;
    localparam int HDR_R0DATA_OFS = 2;
    localparam int R0_DEPTH_DEF   = 8;

endpackage

// File: rtl/core_msg_rx_ibuf.sv
// Instruction buffer: one write port and one registered read port; a read of the
// address being written in the same cycle returns the previous contents.
module core_ibuf #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];
    logic [15:0] rdata_p1;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rdata_p1 <= mem[rd_addr];
    end

    assign rd_data = rdata_p1;

endmodule

// File: rtl/core_msg_rx.sv
// Per-core task message receiver: parses scheduler task streams, loads the instruction
// buffer and launches execution. Define CORE_MSG_RX_ERR_EN to build the sticky rx_err logic.
module core_msg_rx
    import core_msg_rx_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int BUS_TO_CORE = 16,
    parameter int R0_DEPTH    = R0_DEPTH_DEF,
    parameter int IBUF_DEPTH  = 256,
    localparam int AW         = $clog2(IBUF_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   msg_valid,
    input  logic                   msg_sof,
    input  logic [BUS_TO_CORE-1:0] msg_data,
    output logic                   core_ready,
    output logic                   exec_start,
    input  logic                   exec_done,
    input  logic [AW-1:0]          ibuf_raddr,
    output logic [15:0]            ibuf_rdata,
    output logic [AW:0]            instr_count,
    output logic [15:0]            r0_init,
    output logic                   r0_init_valid,
    output logic                   rx_err
);

    localparam int          R0W      = $clog2(R0_DEPTH + 1);
    localparam logic [R0W-1:0] R0_SEL = R0W'(CORE_ID % R0_DEPTH);
    localparam logic [R0W-1:0] R0_END = R0W'(R0_DEPTH);
    localparam logic [15:0] IBUF_LIM = 16'(IBUF_DEPTH);

    rx_state_t       state, state_nxt;
    logic            busy, busy_nxt, task_sel;
    logic [R0W-1:0]  r0_idx;
    logic [15:0]     n_words, instr_idx;
    logic [15:0]     data16;
    logic            do_mask, do_r0mask, do_r0data, do_cnt, do_instr, last_instr;
    logic            abort_sel, busy_eff, sel_now, in_range;

    assign data16   = msg_data[15:0];
    assign in_range = instr_idx < IBUF_LIM;
    // An aborted task that owned the core releases it before the new mask is judged
    assign busy_eff = busy & ~abort_sel;
    assign sel_now  = do_mask & msg_data[CORE_ID] & ~busy_eff;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_mask    = 1'b0;
        do_r0mask  = 1'b0;
        do_r0data  = 1'b0;
        do_cnt     = 1'b0;
        do_instr   = 1'b0;
        last_instr = 1'b0;
        abort_sel  = 1'b0;
        if (msg_valid) begin
            if (msg_sof) begin
                do_mask   = 1'b1;
                abort_sel = (state != ST_IDLE) && task_sel;
                state_nxt = ST_MASK;
            end else begin
                case (state)
                    ST_MASK: begin
                        do_r0mask = 1'b1;
                        state_nxt = ST_R0MASK;
                    end
                    ST_R0MASK, ST_R0DATA: begin
                        if (r0_idx == R0_END) begin
                            do_cnt    = 1'b1;
                            state_nxt = (data16 == 16'd0) ? ST_IDLE : ST_ICNT;
                        end else begin
                            do_r0data = 1'b1;
                            state_nxt = ST_R0DATA;
                        end
                    end
                    ST_ICNT, ST_INSTR: begin
                        do_instr   = 1'b1;
                        last_instr = (instr_idx == n_words - 16'd1);
                        state_nxt  = last_instr ? ST_IDLE : ST_INSTR;
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_comb begin
        busy_nxt = busy;
        if (busy && exec_done)
            busy_nxt = 1'b0;
        if (abort_sel)
            busy_nxt = 1'b0;
        if (sel_now)
            busy_nxt = 1'b1;
        if (do_cnt && task_sel && data16 == 16'd0)
            busy_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy          <= 1'b0;
            task_sel      <= 1'b0;
            exec_start    <= 1'b0;
            r0_idx        <= '0;
            instr_idx     <= '0;
            instr_count   <= '0;
            r0_init       <= '0;
            r0_init_valid <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            exec_start <= do_instr & last_instr & task_sel;
            if (do_mask) begin
                task_sel <= sel_now;
                r0_idx   <= '0;
            end
            if (do_r0mask && task_sel)
                r0_init_valid <= msg_data[CORE_ID];
            if (do_r0data) begin
                r0_idx <= r0_idx + R0W'(1);
                if (task_sel && r0_idx == R0_SEL)
                    r0_init <= data16;
            end
            if (do_cnt) begin
                instr_idx <= '0;
                if (task_sel)
                    instr_count <= (data16 >= IBUF_LIM) ? (AW+1)'(IBUF_DEPTH) : data16[AW:0];
            end
            if (do_instr)
                instr_idx <= instr_idx + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_cnt)
            n_words <= data16;
    end

`ifdef CORE_MSG_RX_ERR_EN
    logic rx_err_q;
    always_ff @(posedge clk) begin
        if (reset)
            rx_err_q <= 1'b0;
        else if ((do_mask && msg_data[CORE_ID] && busy_eff) ||
                 (do_instr && task_sel && !in_range))
            rx_err_q <= 1'b1;
    end
    assign rx_err = rx_err_q;
`else
    assign rx_err = 1'b0;
`endif

    assign core_ready = ~busy;

    core_ibuf #(
        .DEPTH (IBUF_DEPTH),
        .AW    (AW)
    ) u_ibuf (
        .clk     (clk),
        .wr_en   (do_instr & task_sel & in_range),
        .wr_addr (instr_idx[AW-1:0]),
        .wr_data (data16),
        .rd_addr (ibuf_raddr),
        .rd_data (ibuf_rdata)
    );

endmodule

// File: tb/tb_core_msg_rx.sv
// Directed bench for core_msg_rx with CORE_ID=3, R0_DEPTH=8, IBUF_DEPTH=256.
module tb_core_msg_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        msg_valid = 1'b0;
    logic        msg_sof = 1'b0;
    logic [15:0] msg_data = '0;
    logic        core_ready;
    logic        exec_start;
    logic        exec_done = 1'b0;
    logic [7:0]  ibuf_raddr = '0;
    logic [15:0] ibuf_rdata;
    logic [8:0]  instr_count;
    logic [15:0] r0_init;
    logic        r0_init_valid;
    logic        rx_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exec_cnt = 0;

`ifdef CORE_MSG_RX_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    core_msg_rx #(
        .CORE_ID     (3),
        .BUS_TO_CORE (16),
        .R0_DEPTH    (8),
        .IBUF_DEPTH  (256)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .msg_valid     (msg_valid),
        .msg_sof       (msg_sof),
        .msg_data      (msg_data),
        .core_ready    (core_ready),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .ibuf_raddr    (ibuf_raddr),
        .ibuf_rdata    (ibuf_rdata),
        .instr_count   (instr_count),
        .r0_init       (r0_init),
        .r0_init_valid (r0_init_valid),
        .rx_err        (rx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (exec_start === 1'b1)
            exec_cnt++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic sof, input logic [15:0] d, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                msg_valid = 1'b0;
                msg_sof   = 1'($urandom);
                msg_data  = 16'($urandom);
                tick(1);
            end
        end
        msg_valid = 1'b1;
        msg_sof   = sof;
        msg_data  = d;
        tick(1);
        msg_valid = 1'b0;
        msg_sof   = 1'b0;
    endtask

    task automatic send_task(input logic [15:0] mask, input logic [15:0] r0mask,
                             input logic [15:0] r0base, input logic [15:0] n,
                             input logic [15:0] ibase, input int n_send, input bit gaps);
        send_word(1'b1, mask, gaps);
        send_word(1'b0, r0mask, gaps);
        for (int i = 0; i < 8; i++)
            send_word(1'b0, r0base + 16'(i), gaps);
        send_word(1'b0, n, gaps);
        for (int i = 0; i < n_send; i++)
            send_word(1'b0, ibase + 16'(i), gaps);
    endtask

    task automatic read_ibuf(input logic [7:0] a, output logic [15:0] d);
        ibuf_raddr = a;
        tick(1);
        d = ibuf_rdata;
    endtask

    task automatic finish_exec();
        exec_done = 1'b1;
        tick(1);
        exec_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL reset_core_ready got %b want 1", core_ready); end
        n_checks++; if (exec_start !== 1'b0) begin n_fail++; $display("FAIL reset_exec_start got %b want 0", exec_start); end
        n_checks++; if (instr_count !== 9'd0) begin n_fail++; $display("FAIL reset_instr_count got %0d want 0", instr_count); end
        n_checks++; if (r0_init !== 16'h0) begin n_fail++; $display("FAIL reset_r0_init got %h want 0000", r0_init); end
        n_checks++; if (r0_init_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r0_valid got %b want 0", r0_init_valid); end
        n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_rx_err got %b want 0", rx_err); end
    endtask

    task automatic check_basic(input string tag, input bit gaps);
        logic [15:0] d;
        exec_cnt = 0;
        send_word(1'b1, 16'h0008, gaps);
        n_checks++; if (core_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_fall got %b want 0", tag, core_ready); end
        send_word(1'b0, 16'h0008, gaps);
        for (int i = 0; i < 8; i++)
            send_word(1'b0, 16'h1000 + 16'(i), gaps);
        send_word(1'b0, 16'd4, gaps);
        for (int i = 0; i < 4; i++)
            send_word(1'b0, 16'hA000 + 16'(i), gaps);
        tick(3);
        n_checks++; if (exec_cnt !== 1) begin n_fail++; $display("FAIL %s_exec_pulses got %0d want 1", tag, exec_cnt); end
        n_checks++; if (r0_init !== 16'h1003) begin n_fail++; $display("FAIL %s_r0_init got %h want 1003", tag, r0_init); end
        n_checks++; if (r0_init_valid !== 1'b1) begin n_fail++; $display("FAIL %s_r0_valid got %b want 1", tag, r0_init_valid); end
        n_checks++; if (instr_count !== 9'd4) begin n_fail++; $display("FAIL %s_instr_count got %0d want 4", tag, instr_count); end
        n_checks++; if (core_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_held got %b want 0", tag, core_ready); end
        for (int i = 0; i < 4; i++) begin
            read_ibuf(8'(i), d);
            n_checks++; if (d !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL %s_ibuf[%0d] got %h want %h", tag, i, d, 16'hA000 + 16'(i)); end
        end
        finish_exec();
        n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready_after_done got %b want 1", tag, core_ready); end
    endtask

    task automatic test_basic();
        check_basic("basic", 1'b0);
    endtask

    task automatic test_not_selected();
        logic [15:0] d;
        exec_cnt = 0;
        send_word(1'b1, 16'h0004, 1'b0);
        n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL unsel_ready got %b want 1", core_ready); end
        send_word(1'b0, 16'h0008, 1'b0);
        for (int i = 0; i < 8; i++)
            send_word(1'b0, 16'h2000 + 16'(i), 1'b0);
        send_word(1'b0, 16'd3, 1'b0);
        for (int i = 0; i < 3; i++)
            send_word(1'b0, 16'hB000 + 16'(i), 1'b0);
        tick(3);
        n_checks++; if (exec_cnt !== 0) begin n_fail++; $display("FAIL unsel_exec_pulses got %0d want 0", exec_cnt); end
        n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL unsel_ready_end got %b want 1", core_ready); end
        n_checks++; if (instr_count !== 9'd4) begin n_fail++; $display("FAIL unsel_instr_count got %0d want 4", instr_count); end
        n_checks++; if (r0_init !== 16'h1003) begin n_fail++; $display("FAIL unsel_r0_init got %h want 1003", r0_init); end
        for (int i = 0; i < 3; i++) begin
            read_ibuf(8'(i), d);
            n_checks++; if (d !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL unsel_ibuf[%0d] got %h want %h", i, d, 16'hA000 + 16'(i)); end
        end
    endtask

    task automatic test_busy_conflict();
        logic [15:0] d;
        exec_cnt = 0;
        ibuf_raddr = 8'd0;
        send_task(16'h0008, 16'h0008, 16'h3000, 16'd2, 16'h0, 0, 1'b0);
        send_word(1'b0, 16'hC000, 1'b0);
        n_checks++; if (ibuf_rdata !== 16'hA000) begin n_fail++; $display("FAIL rw_same_addr_old got %h want a000", ibuf_rdata); end
        send_word(1'b0, 16'hC001, 1'b0);
        n_checks++; if (ibuf_rdata !== 16'hC000) begin n_fail++; $display("FAIL rw_next_read_new got %h want c000", ibuf_rdata); end
        send_task(16'h0008, 16'h0008, 16'h7000, 16'd2, 16'hD000, 2, 1'b0);
        tick(2);
        n_checks++; if (rx_err !== EXP_ERR) begin n_fail++; $display("FAIL busy_rx_err got %b want %b", rx_err, EXP_ERR); end
        n_checks++; if (exec_cnt !== 1) begin n_fail++; $display("FAIL busy_exec_pulses got %0d want 1", exec_cnt); end
        n_checks++; if (r0_init !== 16'h3003) begin n_fail++; $display("FAIL busy_r0_init got %h want 3003", r0_init); end
        n_checks++; if (instr_count !== 9'd2) begin n_fail++; $display("FAIL busy_instr_count got %0d want 2", instr_count); end
        for (int i = 0; i < 2; i++) begin
            read_ibuf(8'(i), d);
            n_checks++; if (d !== 16'hC000 + 16'(i)) begin n_fail++; $display("FAIL busy_ibuf[%0d] got %h want %h", i, d, 16'hC000 + 16'(i)); end
        end
        finish_exec();
    endtask

    task automatic test_zero_n();
        exec_cnt = 0;
        send_task(16'h0008, 16'h0000, 16'h8000, 16'd0, 16'h0, 0, 1'b0);
        n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL zero_n_ready got %b want 1", core_ready); end
        n_checks++; if (r0_init_valid !== 1'b0) begin n_fail++; $display("FAIL zero_n_r0_valid got %b want 0", r0_init_valid); end
        n_checks++; if (instr_count !== 9'd0) begin n_fail++; $display("FAIL zero_n_instr_count got %0d want 0", instr_count); end
        tick(3);
        n_checks++; if (exec_cnt !== 0) begin n_fail++; $display("FAIL zero_n_exec_pulses got %0d want 0", exec_cnt); end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        do_reset();
        exec_cnt = 0;
        send_task(16'h0008, 16'h0008, 16'h1000, 16'd300, 16'h4000, 299, 1'b0);
        tick(2);
        n_checks++; if (exec_cnt !== 0) begin n_fail++; $display("FAIL ovf_early_exec got %0d want 0", exec_cnt); end
        send_word(1'b0, 16'h4000 + 16'd299, 1'b0);
        tick(2);
        n_checks++; if (exec_cnt !== 1) begin n_fail++; $display("FAIL ovf_exec_pulses got %0d want 1", exec_cnt); end
        n_checks++; if (instr_count !== 9'd256) begin n_fail++; $display("FAIL ovf_instr_count got %0d want 256", instr_count); end
        n_checks++; if (rx_err !== EXP_ERR) begin n_fail++; $display("FAIL ovf_rx_err got %b want %b", rx_err, EXP_ERR); end
        read_ibuf(8'd0, d);
        n_checks++; if (d !== 16'h4000) begin n_fail++; $display("FAIL ovf_ibuf[0] got %h want 4000", d); end
        read_ibuf(8'd255, d);
        n_checks++; if (d !== 16'h40FF) begin n_fail++; $display("FAIL ovf_ibuf[255] got %h want 40ff", d); end
        finish_exec();
    endtask

    task automatic test_abort();
        logic [15:0] d;
        do_reset();
        exec_cnt = 0;
        send_word(1'b1, 16'h0008, 1'b0);
        send_word(1'b0, 16'h0008, 1'b0);
        send_word(1'b0, 16'h5000, 1'b0);
        send_task(16'h0008, 16'h0008, 16'h6000, 16'd2, 16'hE000, 2, 1'b0);
        tick(2);
        n_checks++; if (exec_cnt !== 1) begin n_fail++; $display("FAIL abort_exec_pulses got %0d want 1", exec_cnt); end
        n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL abort_rx_err got %b want 0", rx_err); end
        n_checks++; if (r0_init !== 16'h6003) begin n_fail++; $display("FAIL abort_r0_init got %h want 6003", r0_init); end
        n_checks++; if (instr_count !== 9'd2) begin n_fail++; $display("FAIL abort_instr_count got %0d want 2", instr_count); end
        for (int i = 0; i < 2; i++) begin
            read_ibuf(8'(i), d);
            n_checks++; if (d !== 16'hE000 + 16'(i)) begin n_fail++; $display("FAIL abort_ibuf[%0d] got %h want %h", i, d, 16'hE000 + 16'(i)); end
        end
        finish_exec();
    endtask

    task automatic test_gaps();
        do_reset();
        check_basic("gaps", 1'b1);
    endtask

    task automatic test_reset_mid();
        exec_cnt = 0;
        send_task(16'h0008, 16'h0008, 16'h1000, 16'd4, 16'hF000, 2, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        send_word(1'b0, 16'hF002, 1'b0);
        send_word(1'b0, 16'hF003, 1'b0);
        tick(3);
        n_checks++; if (exec_cnt !== 0) begin n_fail++; $display("FAIL rstmid_exec_pulses got %0d want 0", exec_cnt); end
        n_checks++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", core_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_not_selected();
        test_busy_conflict();
        test_zero_n();
        test_overflow();
        test_abort();
        test_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
